conv_grp_task_sched: RTL

Layer-level task scheduler for the generic convolution engine. On a start pulse it latches the runtime base addresses and group-conv parameters, then issues one task descriptor per group to the downstream fetch/compute front end over a valid/ready handshake. It tracks outstanding groups against completion pulses from the packer and gates the MAC array and packer enables. It sits between the runtime config registers and the compute datapath.

---
 rtl/conv_grp_task_sched.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/conv_grp_task_sched.sv
// conv_grp_task_sched: layer-level task scheduler for the convolution engine.
// When a start pulse arrives, the scheduler latches the base addresses and the
// group parameters. It then issues one descriptor per group over a valid/ready
// channel and limits the number of groups in flight. A layer ends after every
// issued group has been reported complete by the packer.
//
// Handshake: task_valid and the payload are held stable from the first cycle
// valid is seen until task_ready is sampled high on a rising clk edge. A
// transfer happens on any edge where task_valid && task_ready are both high.
module conv_grp_task_sched #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              is_grp_conv_mode,
    input  logic [15:0]       group_n,
    input  logic [ADDR_W-1:0] ifmap_baseaddr,
    input  logic [ADDR_W-1:0] ofmap_baseaddr,
    input  logic [ADDR_W-1:0] kernal_wgt_baseaddr,
    input  logic [31:0]       data_size_foreach_group,
    input  logic [31:0]       ofmap_size_foreach_group,
    input  logic [31:0]       wgt_size_foreach_group,
    input  logic              grp_done,
    output logic              task_valid,
    input  logic              task_ready,
    output logic [15:0]       task_grp_id,
    output logic [ADDR_W-1:0] task_ifmap_addr,
    output logic [ADDR_W-1:0] task_ofmap_addr,
    output logic [ADDR_W-1:0] task_wgt_addr,
    output logic              task_last,
    output logic              en_mac_array,
    output logic              en_packer,
    output logic              busy,
    output logic              done,
    output logic              err_spurious_done
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, FIN = 2'd3} state_t;

    localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

    // state_q is kept as a named enum so that checkers can bind to it directly.
    state_t            state_q;
    logic [2:0]        out_q;      // groups issued in this layer and not yet completed
    logic [2:0]        orphan_q;   // groups still in flight from an aborted layer
    logic [15:0]       grp_cnt_q;
    logic [15:0]       grp_total_q;
    logic [ADDR_W-1:0] ifm_acc_q, ofm_acc_q, wgt_acc_q;
    logic [ADDR_W-1:0] ifm_str_q, ofm_str_q, wgt_str_q;
    logic              busy_q, en_q, done_q, err_q;

    logic              grp_done_eff;
    logic              hs;
    logic              spurious;
    logic [2:0]        out_nxt;
    logic [3:0]        orphan_sum;
    logic [2:0]        orphan_sat;

    // Combinational part: the valid/transfer decision and the next outstanding count.
    // A completion pulse is first used to retire a group left over from an abort.
    always_comb begin
        grp_done_eff = grp_done && (orphan_q == 3'd0);
        task_valid   = (state_q == ISSUE) && ((out_q < MAX_OUT) || grp_done_eff);
        hs           = task_valid && task_ready;
        spurious     = grp_done_eff && !hs && (out_q == 3'd0);
        out_nxt      = out_q;
        if (hs && !grp_done_eff) begin
            out_nxt = out_q + 3'd1;
        end else if (!hs && grp_done_eff && (out_q != 3'd0)) begin
            out_nxt = out_q - 3'd1;
        end
        orphan_sum = {1'b0, orphan_q} + {1'b0, out_nxt}
                   - {3'b000, (grp_done && (orphan_q != 3'd0))};
        orphan_sat = (orphan_sum > 4'd7) ? 3'd7 : orphan_sum[2:0];
    end

    assign task_grp_id       = grp_cnt_q;
    assign task_ifmap_addr   = ifm_acc_q;
    assign task_ofmap_addr   = ofm_acc_q;
    assign task_wgt_addr     = wgt_acc_q;
    assign task_last         = (state_q == ISSUE) && (grp_cnt_q == grp_total_q);
    assign en_mac_array      = en_q;
    assign en_packer         = en_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign err_spurious_done = err_q;

    // Scheduler FSM. It also updates the counters, the address accumulators and the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_q       <= '0;
            orphan_q    <= '0;
            grp_cnt_q   <= '0;
            grp_total_q <= '0;
            ifm_acc_q   <= '0;
            ofm_acc_q   <= '0;
            wgt_acc_q   <= '0;
            ifm_str_q   <= '0;
            ofm_str_q   <= '0;
            wgt_str_q   <= '0;
            busy_q      <= 1'b0;
            en_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (spurious) begin
                err_q <= 1'b1;
            end
            if (abort && (state_q != IDLE)) begin
                // Groups already handed downstream will still report completion.
                // They are counted here so that those late pulses are absorbed.
                state_q  <= IDLE;
                out_q    <= '0;
                orphan_q <= orphan_sat;
                busy_q   <= 1'b0;
                en_q     <= 1'b0;
            end else begin
                out_q <= out_nxt;
                if (grp_done && (orphan_q != 3'd0)) begin
                    orphan_q <= orphan_q - 3'd1;
                end
                case (state_q)
                    IDLE: begin
                        if (start && !abort) begin
                            ifm_acc_q   <= ifmap_baseaddr;
                            ofm_acc_q   <= ofmap_baseaddr;
                            wgt_acc_q   <= kernal_wgt_baseaddr;
                            ifm_str_q   <= ADDR_W'(data_size_foreach_group);
                            ofm_str_q   <= ADDR_W'(ofmap_size_foreach_group);
                            wgt_str_q   <= ADDR_W'(wgt_size_foreach_group);
                            grp_total_q <= is_grp_conv_mode ? group_n : 16'd0;
                            grp_cnt_q   <= '0;
                            out_q       <= '0;
                            busy_q      <= 1'b1;
                            en_q        <= 1'b1;
                            state_q     <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (hs) begin
                            ifm_acc_q <= ifm_acc_q + ifm_str_q;
                            ofm_acc_q <= ofm_acc_q + ofm_str_q;
                            wgt_acc_q <= wgt_acc_q + wgt_str_q;
                            grp_cnt_q <= grp_cnt_q + 16'd1;
                            if (task_last) begin
                                state_q <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (out_q == 3'd0) begin
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end
                    end
                    FIN: begin
                        busy_q  <= 1'b0;
                        en_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
